// File: rtl/bus_split_arbiter.sv
// Two-master bus arbiter with single-outstanding split-transaction parking
// and a BUSY-cycle watchdog that revokes a stuck grant.
module bus_split_arbiter #(
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT     = 200,
    parameter int TIMEOUT_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    input  logic [2:0]           s_split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arbiter_busy,
    output logic                 bus_busy,
    output logic [SLAVE_LEN-1:0] bus_slave_sel,
    output logic                 m1_split,
    output logic                 m2_split,
    output logic                 timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [SLAVE_LEN-1:0]   SEL_RSVD = SLAVE_LEN'(3);
    localparam logic [TIMEOUT_LEN-1:0] WD_LAST  = TIMEOUT_LEN'(TIMEOUT - 1);

    // Split-enable bit of the given slave; the reserved code never splits.
    function automatic logic split_bit(input logic [2:0] vec, input logic [SLAVE_LEN-1:0] sel);
        logic bit_v;
        case (sel)
            SLAVE_LEN'(0): bit_v = vec[0];
            SLAVE_LEN'(1): bit_v = vec[1];
            SLAVE_LEN'(2): bit_v = vec[2];
            default:       bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    state_t                 state_q, state_d;
    logic                   winner_q, winner_d;        // 1 = m2 owns the arbitration result
    logic [SLAVE_LEN-1:0]   sel_q, sel_d;
    logic                   arb_busy_q, arb_busy_d;
    logic                   bus_busy_q, bus_busy_d;
    logic                   m1_grant_q, m1_grant_d;
    logic                   m2_grant_q, m2_grant_d;
    logic                   m1_split_q, m1_split_d;
    logic                   m2_split_q, m2_split_d;
    logic                   timeout_q, timeout_d;
    logic                   split_valid_q, split_valid_d;
    logic                   split_master_q, split_master_d;
    logic [SLAVE_LEN-1:0]   split_slave_q, split_slave_d;
    logic [2:0]             split_prev_q;
    logic [TIMEOUT_LEN-1:0] wd_q, wd_d;

    logic park_en_s, rise_s, wd_hit_s, cancel_s;
    logic m1_block_s, m2_block_s, m1_elig_s, m2_elig_s, resume_s, pick_m2_s;

    // The parked master may only return once its slave drops split; the other
    // master is locked out of the parked slave until then.
    assign park_en_s  = split_bit(s_split_en, split_slave_q);
    assign m1_block_s = split_valid_q && (split_master_q ? (m1_slave_sel == split_slave_q) : park_en_s);
    assign m2_block_s = split_valid_q && (split_master_q ? park_en_s : (m2_slave_sel == split_slave_q));
    assign m1_elig_s  = m1_request && (m1_slave_sel != SEL_RSVD) && !m1_block_s;
    assign m2_elig_s  = m2_request && (m2_slave_sel != SEL_RSVD) && !m2_block_s;
    assign resume_s   = split_valid_q && (split_master_q ? m2_elig_s : m1_elig_s);
    assign pick_m2_s  = resume_s ? split_master_q : !m1_elig_s;
    assign rise_s     = split_bit(s_split_en, sel_q) && !split_bit(split_prev_q, sel_q);
    assign wd_hit_s   = (TIMEOUT != 0) && (wd_q == WD_LAST);
    assign cancel_s   = split_valid_q && !(split_master_q ? m2_request : m1_request);

    // Next-state, split bookkeeping and registered-output values.
    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        sel_d          = sel_q;
        arb_busy_d     = 1'b0;
        bus_busy_d     = 1'b0;
        m1_grant_d     = 1'b0;
        m2_grant_d     = 1'b0;
        timeout_d      = 1'b0;
        wd_d           = '0;
        split_valid_d  = split_valid_q && !cancel_s;
        split_master_d = split_master_q;
        split_slave_d  = split_slave_q;
        case (state_q)
            ST_IDLE: begin
                if (m1_elig_s || m2_elig_s) begin
                    state_d    = ST_ARB;
                    winner_d   = pick_m2_s;
                    sel_d      = pick_m2_s ? m2_slave_sel : m1_slave_sel;
                    arb_busy_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                state_d    = ST_BUSY;
                bus_busy_d = 1'b1;
                m1_grant_d = !winner_q;
                m2_grant_d = winner_q;
                if (split_valid_q && (split_master_q == winner_q)) begin
                    split_valid_d = 1'b0;
                end else begin
                    split_valid_d = split_valid_q && !cancel_s;
                end
            end
            ST_BUSY: begin
                if (trans_done || rise_s || wd_hit_s) begin
                    state_d   = ST_RELEASE;
                    timeout_d = !trans_done && !rise_s;
                    // A second split while one is pending closes like a normal transfer.
                    if (!trans_done && rise_s && !split_valid_q) begin
                        split_valid_d  = 1'b1;
                        split_master_d = winner_q;
                        split_slave_d  = sel_q;
                    end else begin
                        split_master_d = split_master_q;
                    end
                end else begin
                    state_d    = ST_BUSY;
                    bus_busy_d = 1'b1;
                    m1_grant_d = m1_grant_q;
                    m2_grant_d = m2_grant_q;
                    wd_d       = wd_q + TIMEOUT_LEN'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        m1_split_d = split_valid_d && !split_master_d;
        m2_split_d = split_valid_d && split_master_d;
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            winner_q       <= 1'b0;
            sel_q          <= '0;
            arb_busy_q     <= 1'b0;
            bus_busy_q     <= 1'b0;
            m1_grant_q     <= 1'b0;
            m2_grant_q     <= 1'b0;
            m1_split_q     <= 1'b0;
            m2_split_q     <= 1'b0;
            timeout_q      <= 1'b0;
            split_valid_q  <= 1'b0;
            split_master_q <= 1'b0;
            split_slave_q  <= '0;
            split_prev_q   <= 3'b000;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            sel_q          <= sel_d;
            arb_busy_q     <= arb_busy_d;
            bus_busy_q     <= bus_busy_d;
            m1_grant_q     <= m1_grant_d;
            m2_grant_q     <= m2_grant_d;
            m1_split_q     <= m1_split_d;
            m2_split_q     <= m2_split_d;
            timeout_q      <= timeout_d;
            split_valid_q  <= split_valid_d;
            split_master_q <= split_master_d;
            split_slave_q  <= split_slave_d;
            split_prev_q   <= s_split_en;
            wd_q           <= wd_d;
        end
    end

    assign m1_grant      = m1_grant_q;
    assign m2_grant      = m2_grant_q;
    assign arbiter_busy  = arb_busy_q;
    assign bus_busy      = bus_busy_q;
    assign bus_slave_sel = sel_q;
    assign m1_split      = m1_split_q;
    assign m2_split      = m2_split_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (owner / winner / cool-down).
module tb_bus_split_arbiter;

    localparam int TO_A = 10;

    logic       clk;
    logic       reset;
    logic       m1_request, m2_request;
    logic [1:0] m1_slave_sel, m2_slave_sel;
    logic       trans_done;
    logic [2:0] s_split_en;

    logic       a_m1_grant, a_m2_grant, a_arb, a_bb, a_m1s, a_m2s, a_to;
    logic [1:0] a_sel;
    logic       b_m1_grant, b_m2_grant, b_arb, b_bb, b_m1s, b_m2s, b_to;
    logic [1:0] b_sel;
    logic [8:0] a_out, b_out;

    assign a_out = {a_m1_grant, a_m2_grant, a_arb, a_bb, a_sel, a_m1s, a_m2s, a_to};
    assign b_out = {b_m1_grant, b_m2_grant, b_arb, b_bb, b_sel, b_m1s, b_m2s, b_to};

    int checks = 0;
    int errors = 0;

    bus_split_arbiter #(.SLAVE_LEN(2), .TIMEOUT(TO_A), .TIMEOUT_LEN(8)) dut_a (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done), .s_split_en(s_split_en),
        .m1_grant(a_m1_grant), .m2_grant(a_m2_grant), .arbiter_busy(a_arb),
        .bus_busy(a_bb), .bus_slave_sel(a_sel), .m1_split(a_m1s), .m2_split(a_m2s),
        .timeout_pulse(a_to)
    );

    bus_split_arbiter #(.SLAVE_LEN(2), .TIMEOUT(0), .TIMEOUT_LEN(8)) dut_b (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done), .s_split_en(s_split_en),
        .m1_grant(b_m1_grant), .m2_grant(b_m2_grant), .arbiter_busy(b_arb),
        .bus_busy(b_bb), .bus_slave_sel(b_sel), .m1_split(b_m1s), .m2_split(b_m2s),
        .timeout_pulse(b_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the bus, who won arbitration, cool-down cycle,
    // cycles owned so far, and the parked (master, slave) record.
    int       md_owner, md_win, md_cnt, md_pm;
    bit       md_cool, md_pv, md_to;
    bit [1:0] md_sel, md_ps;
    bit [2:0] md_prev;

    task automatic md_reset();
        md_owner = 0; md_win = 0; md_cnt = 0; md_pm = 0;
        md_cool = 1'b0; md_pv = 1'b0; md_to = 1'b0;
        md_sel = 2'd0; md_ps = 2'd0; md_prev = 3'b000;
    endtask

    function automatic bit md_elig(input int m);
        bit       r;
        bit [1:0] s;
        r = (m == 1) ? m1_request : m2_request;
        s = (m == 1) ? m1_slave_sel : m2_slave_sel;
        if (!r || s == 2'd3) return 1'b0;
        if (!md_pv) return 1'b1;
        if (md_pm == m) return !s_split_en[md_ps];
        return s != md_ps;
    endfunction

    task automatic md_step();
        bit e1, e2, cancel, rise;
        e1     = md_elig(1);
        e2     = md_elig(2);
        cancel = md_pv && ((md_pm == 1) ? !m1_request : !m2_request);
        md_to  = 1'b0;
        if (md_owner != 0) begin
            md_cnt++;
            rise = (md_sel != 2'd3) && s_split_en[md_sel] && !md_prev[md_sel];
            if (trans_done || rise || md_cnt == TO_A) begin
                if (!trans_done && rise && !md_pv) begin
                    md_pv = 1'b1; md_pm = md_owner; md_ps = md_sel;
                end else if (!trans_done && !rise) begin
                    md_to = 1'b1;
                end
                md_owner = 0; md_cool = 1'b1; md_cnt = 0;
            end
        end else if (md_win != 0) begin
            md_owner = md_win; md_win = 0;
            if (md_pv && md_pm == md_owner) md_pv = 1'b0;
        end else if (md_cool) begin
            md_cool = 1'b0;
        end else begin
            if (md_pv && ((md_pm == 1) ? e1 : e2)) md_win = md_pm;
            else if (e1) md_win = 1;
            else if (e2) md_win = 2;
            if (md_win != 0) md_sel = (md_win == 1) ? m1_slave_sel : m2_slave_sel;
        end
        if (cancel) md_pv = 1'b0;
        md_prev = s_split_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m1_request = 1'b0; m2_request = 1'b0;
        m1_slave_sel = 2'd0; m2_slave_sel = 2'd0;
        trans_done = 1'b0; s_split_en = 3'b000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        md_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        m1_request = 1'b1;
        #3;
        checks++; if (a_out !== 9'b0000_00_000) begin errors++; $display("FAIL reset_a got %b want %b", a_out, 9'b0000_00_000); end
        checks++; if (b_out !== 9'b0000_00_000) begin errors++; $display("FAIL reset_b got %b want %b", b_out, 9'b0000_00_000); end
        tick();
        reset = 1'b0;
        m1_request = 1'b0;
        tick();
        checks++; if (a_out !== 9'b0000_00_000) begin errors++; $display("FAIL reset_idle got %b want %b", a_out, 9'b0000_00_000); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick();
        checks++; if (a_out !== 9'b0010_00_000) begin errors++; $display("FAIL sim_arb got %b want %b", a_out, 9'b0010_00_000); end
        tick();
        checks++; if (a_out !== 9'b1001_00_000) begin errors++; $display("FAIL sim_m1_grant got %b want %b", a_out, 9'b1001_00_000); end
        repeat (3) tick();
        checks++; if (a_out !== 9'b1001_00_000) begin errors++; $display("FAIL sim_m1_hold got %b want %b", a_out, 9'b1001_00_000); end
        trans_done = 1'b1; m1_request = 1'b0;
        tick();
        trans_done = 1'b0;
        checks++; if (a_out !== 9'b0000_00_000) begin errors++; $display("FAIL sim_release got %b want %b", a_out, 9'b0000_00_000); end
        tick();
        checks++; if (a_out !== 9'b0000_00_000) begin errors++; $display("FAIL sim_idle_gap got %b want %b", a_out, 9'b0000_00_000); end
        tick();
        checks++; if (a_out !== 9'b0010_01_000) begin errors++; $display("FAIL sim_m2_arb got %b want %b", a_out, 9'b0010_01_000); end
        tick();
        checks++; if (a_out !== 9'b0101_01_000) begin errors++; $display("FAIL sim_m2_grant got %b want %b", a_out, 9'b0101_01_000); end
        trans_done = 1'b1; m2_request = 1'b0;
        tick();
        trans_done = 1'b0;
        tick();
    endtask

    task automatic test_split_resume();
        do_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        repeat (2) tick();
        checks++; if (a_out !== 9'b1001_01_000) begin errors++; $display("FAIL split_pre got %b want %b", a_out, 9'b1001_01_000); end
        s_split_en = 3'b010;
        tick();
        checks++; if (a_out !== 9'b0000_01_100) begin errors++; $display("FAIL split_park got %b want %b", a_out, 9'b0000_01_100); end
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        repeat (3) tick();
        checks++; if (a_out !== 9'b0000_01_100) begin errors++; $display("FAIL split_lockout got %b want %b", a_out, 9'b0000_01_100); end
        m2_slave_sel = 2'd2;
        tick();
        checks++; if (a_out !== 9'b0010_10_100) begin errors++; $display("FAIL split_m2_arb got %b want %b", a_out, 9'b0010_10_100); end
        tick();
        checks++; if (a_out !== 9'b0101_10_100) begin errors++; $display("FAIL split_m2_grant got %b want %b", a_out, 9'b0101_10_100); end
        s_split_en = 3'b000;
        repeat (2) tick();
        trans_done = 1'b1; m2_slave_sel = 2'd0;
        tick();
        trans_done = 1'b0;
        repeat (2) tick();
        checks++; if (a_out !== 9'b0010_01_100) begin errors++; $display("FAIL resume_arb got %b want %b", a_out, 9'b0010_01_100); end
        tick();
        checks++; if (a_out !== 9'b1001_01_000) begin errors++; $display("FAIL resume_grant got %b want %b", a_out, 9'b1001_01_000); end
        trans_done = 1'b1; m1_request = 1'b0;
        tick();
        trans_done = 1'b0;
        repeat (3) tick();
        checks++; if (a_out !== 9'b0101_00_000) begin errors++; $display("FAIL resume_m2_after got %b want %b", a_out, 9'b0101_00_000); end
        trans_done = 1'b1; m2_request = 1'b0;
        tick();
        trans_done = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int bad;
        do_reset();
        bad = 0;
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        tick();
        for (int i = 0; i < TO_A; i++) begin
            tick();
            if (a_out !== 9'b1001_00_000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wd_hold bad_cycles %0d want 0", bad); end
        tick();
        checks++; if (a_out !== 9'b0000_00_001) begin errors++; $display("FAIL wd_revoke got %b want %b", a_out, 9'b0000_00_001); end
        m1_request = 1'b0;
        tick();
        checks++; if (a_out !== 9'b0000_00_000) begin errors++; $display("FAIL wd_pulse_width got %b want %b", a_out, 9'b0000_00_000); end
        tick();
    endtask

    task automatic test_no_timeout();
        int bad;
        do_reset();
        bad = 0;
        m1_request = 1'b1; m1_slave_sel = 2'd0;
        repeat (2) tick();
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (b_m1_grant !== 1'b1 || b_to !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nowd_hold bad_cycles %0d want 0", bad); end
        do_reset();
    endtask

    task automatic test_reserved_sel();
        int bad;
        do_reset();
        bad = 0;
        m1_request = 1'b1; m1_slave_sel = 2'd3;
        m2_request = 1'b1; m2_slave_sel = 2'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((a_arb | a_m1_grant | a_m2_grant | b_arb | b_m1_grant | b_m2_grant) !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rsvd_never bad_cycles %0d want 0", bad); end
        m2_slave_sel = 2'd2;
        tick();
        checks++; if (a_out !== 9'b0010_10_000) begin errors++; $display("FAIL rsvd_m2_arb got %b want %b", a_out, 9'b0010_10_000); end
        tick();
        checks++; if (a_out !== 9'b0101_10_000) begin errors++; $display("FAIL rsvd_m2_grant got %b want %b", a_out, 9'b0101_10_000); end
        do_reset();
    endtask

    task automatic test_done_and_split();
        do_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        repeat (2) tick();
        trans_done = 1'b1; s_split_en = 3'b010; m1_request = 1'b0;
        tick();
        trans_done = 1'b0;
        checks++; if (a_out !== 9'b0000_01_000) begin errors++; $display("FAIL dsplit_nopark got %b want %b", a_out, 9'b0000_01_000); end
        tick();
        m2_request = 1'b1; m2_slave_sel = 2'd1;
        tick();
        checks++; if (a_out !== 9'b0010_01_000) begin errors++; $display("FAIL dsplit_unlocked got %b want %b", a_out, 9'b0010_01_000); end
        tick();
        checks++; if (a_out !== 9'b0101_01_000) begin errors++; $display("FAIL dsplit_grant got %b want %b", a_out, 9'b0101_01_000); end
        do_reset();
    endtask

    task automatic test_reset_in_busy();
        do_reset();
        m1_request = 1'b1; m1_slave_sel = 2'd1;
        repeat (2) tick();
        s_split_en = 3'b010;
        tick();
        m2_request = 1'b1; m2_slave_sel = 2'd2;
        repeat (3) tick();
        checks++; if (a_out !== 9'b0101_10_100) begin errors++; $display("FAIL rbusy_pre got %b want %b", a_out, 9'b0101_10_100); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (a_out !== 9'b0000_00_000) begin errors++; $display("FAIL rbusy_async got %b want %b", a_out, 9'b0000_00_000); end
        tick();
        reset = 1'b0;
        m2_request = 1'b0;
        tick();
        checks++; if (a_out !== 9'b0010_01_000) begin errors++; $display("FAIL rbusy_record_cleared got %b want %b", a_out, 9'b0010_01_000); end
        tick();
        checks++; if (a_out !== 9'b1001_01_000) begin errors++; $display("FAIL rbusy_regrant got %b want %b", a_out, 9'b1001_01_000); end
        do_reset();
    endtask

    task automatic rand_inputs();
        trans_done = 1'b0;
        if (m1_request) begin
            if (md_owner == 1 && $urandom_range(5, 0) == 0) begin
                trans_done = 1'b1; m1_request = 1'b0;
            end else if ((m1_slave_sel == 2'd3 && $urandom_range(7, 0) == 0) ||
                         (md_pv && md_pm == 1 && $urandom_range(19, 0) == 0)) begin
                m1_request = 1'b0;
            end
        end else if ($urandom_range(3, 0) == 0) begin
            m1_request = 1'b1; m1_slave_sel = 2'($urandom_range(3, 0));
        end
        if (m2_request) begin
            if (md_owner == 2 && $urandom_range(5, 0) == 0) begin
                trans_done = 1'b1; m2_request = 1'b0;
            end else if ((m2_slave_sel == 2'd3 && $urandom_range(7, 0) == 0) ||
                         (md_pv && md_pm == 2 && $urandom_range(19, 0) == 0)) begin
                m2_request = 1'b0;
            end
        end else if ($urandom_range(3, 0) == 0) begin
            m2_request = 1'b1; m2_slave_sel = 2'($urandom_range(3, 0));
        end
        for (int b = 0; b < 3; b++) begin
            if ($urandom_range(9, 0) == 0) s_split_en[b] = ~s_split_en[b];
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_v;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_inputs();
            md_step();
            tick();
            exp_v = {md_owner == 1, md_owner == 2, md_win != 0, md_owner != 0, md_sel,
                     md_pv && md_pm == 1, md_pv && md_pm == 2, md_to};
            checks++;
            if (a_out !== exp_v) begin
                errors++;
                $display("FAIL rand_cycle %0d got %b want %b", cyc, a_out, exp_v);
            end
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        md_reset();
        test_reset();
        test_simultaneous();
        test_split_resume();
        test_watchdog();
        test_no_timeout();
        test_reserved_sel();
        test_done_and_split();
        test_reset_in_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
